// File: rtl/dm_bus_responder_pkg.sv
// Shared types and constants for the data-memory bus responder.
// Holds the FSM encoding, counter width, request bundle and address check.
package dm_bus_responder_pkg;

    localparam int DMB_CNT_W = 4;

    typedef enum logic [1:0] {
        DMB_IDLE = 2'd0,
        DMB_WAIT = 2'd1,
        DMB_RESP = 2'd2
    } dmb_state_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } dmb_req_t;

    // Misaligned, or word index (full 30 bits, unsigned) past the array.
    function automatic logic addr_bad(input logic [31:0] addr,
                                      input logic [31:0] depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Byte-enable merge of write data into an existing 32-bit word.
// Purely combinational; be[i] selects byte lane i from wdata.
module dm_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] merged_word
);

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged_word[8*i +: 8] = wdata[8*i +: 8];
        end
    end

endmodule

// File: rtl/dm_bus_responder.sv
// Valid/ready data-memory responder with fixed, configurable latency.
// One access in flight; write trace is exported as a one-cycle pulse.
module dm_bus_responder
    import dm_bus_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 3072,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [DMB_CNT_W-1:0] CNT_LOAD = DMB_CNT_W'(LATENCY - 1);

    dmb_state_e           state;
    logic [DMB_CNT_W-1:0] cnt;
    dmb_req_t             lat;
    logic [31:0]          mem [DEPTH_WORDS];

    logic [AW-1:0] widx;
    logic [31:0]   old_word;
    logic [31:0]   merged;
    logic          bad;

    assign req_ready = (state == DMB_IDLE) && reset;
    assign widx      = lat.addr[AW+1:2];
    assign bad       = addr_bad(lat.addr, 32'(DEPTH_WORDS));
    assign old_word  = mem[widx];

    dm_byte_merge u_merge (
        .old_word    (old_word),
        .wdata       (lat.wdata),
        .be          (lat.be),
        .merged_word (merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= DMB_IDLE;
            cnt         <= '0;
            lat         <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_addr  <= '0;
            trace_data  <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else begin
            trace_valid <= 1'b0;
            unique case (state)
                DMB_IDLE: begin
                    if (req_valid) begin
                        lat   <= '{we: req_we, be: req_be, addr: req_addr,
                                   wdata: req_wdata, pc: req_pc};
                        cnt   <= CNT_LOAD;
                        state <= DMB_WAIT;
                    end
                end
                DMB_WAIT: begin
                    if (cnt == '0) begin
                        // The array is touched only on the edge entering RESP.
                        state     <= DMB_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= bad;
                        rsp_rdata <= '0;
                        if (!bad && !lat.we) begin
                            rsp_rdata <= old_word;
                        end
                        if (!bad && lat.we && (lat.be != 4'b0000)) begin
                            mem[widx]   <= merged;
                            trace_valid <= 1'b1;
                            trace_pc    <= lat.pc;
                            trace_addr  <= {lat.addr[31:2], 2'b00};
                            trace_data  <= merged;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DMB_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= DMB_IDLE;
                    end
                end
                default: state <= DMB_IDLE;
            endcase
        end
    end

endmodule
